// File: rtl/fetch_line_buffer_if.sv
// Fetch bus: instruction-memory address/line, branch redirect and the decode valid/ready issue port.
// master = fetch_line_buffer side, slave = memory/decode/branch side.
interface fetch_line_buffer_if;
  logic [31:0]  MEM_ADDRESS;
  logic [127:0] INSTRUCTION_SET;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;

  modport master (
    output MEM_ADDRESS, instr_valid, instr, instr_pc,
    input  INSTRUCTION_SET, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  MEM_ADDRESS, instr_valid, instr, instr_pc,
    output INSTRUCTION_SET, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// Times fixed-latency instruction-memory lines and issues one word per cycle; FETCH_PREFETCH_EN adds the NXT prefetch entry.
// Latency: first word valid MEM_LATENCY+1 edges after reset release or redirect; registered outputs.
// Backpressure: outputs hold while instr_valid && !instr_ready; fetch stalls in HOLD when no entry is free.
module fetch_line_buffer #(
  parameter int          MEM_LATENCY = 6,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_line_buffer_if.master bus
);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic {ST_WAIT, ST_HOLD} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [31:0]   r_mem_addr, w_mem_addr;
  logic [1:0]    r_ptr, w_ptr;
  logic          r_cur_vld, w_cur_vld;
  logic [127:0]  r_cur_dat, w_cur_dat;
  logic [27:0]   r_cur_line, w_cur_line;
  logic [31:0]   r_instr, w_instr;
  logic [31:0]   r_instr_pc, w_instr_pc;
  logic          w_xfer, w_cap, w_free;
  logic          w_unused_pc_lsb;
`ifdef FETCH_PREFETCH_EN
  logic          r_nxt_vld, w_nxt_vld;
  logic [127:0]  r_nxt_dat, w_nxt_dat;
  logic [27:0]   r_nxt_line, w_nxt_line;
`endif

  assign w_unused_pc_lsb = ^bus.redirect_pc[1:0];

  function automatic logic [31:0] f_word(input logic [127:0] line, input logic [1:0] ptr);
    case (ptr)
      2'd0:    f_word = line[127:96];
      2'd1:    f_word = line[95:64];
      2'd2:    f_word = line[63:32];
      default: f_word = line[31:0];
    endcase
  endfunction

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_mem_addr = r_mem_addr;
    w_ptr      = r_ptr;
    w_cur_vld  = r_cur_vld;
    w_cur_dat  = r_cur_dat;
    w_cur_line = r_cur_line;
    w_free     = 1'b0;
`ifdef FETCH_PREFETCH_EN
    w_nxt_vld  = r_nxt_vld;
    w_nxt_dat  = r_nxt_dat;
    w_nxt_line = r_nxt_line;
`endif
    w_xfer = r_cur_vld && bus.instr_ready;
    w_cap  = (r_state == ST_WAIT) && (r_cnt == CW'(MEM_LATENCY));

    if (bus.redirect_valid) begin
      // Flush wins over any same-edge transfer or capture; the in-flight line is simply never captured.
      w_cur_vld  = 1'b0;
`ifdef FETCH_PREFETCH_EN
      w_nxt_vld  = 1'b0;
`endif
      w_mem_addr = {bus.redirect_pc[31:4], 4'b0000};
      w_cnt      = '0;
      w_ptr      = bus.redirect_pc[3:2];
      w_state    = ST_WAIT;
    end else begin
      if (w_xfer) begin
        if (r_ptr == 2'd3) begin
          w_ptr = 2'd0;
`ifdef FETCH_PREFETCH_EN
          w_cur_vld  = r_nxt_vld;
          w_cur_dat  = r_nxt_dat;
          w_cur_line = r_nxt_line;
          w_nxt_vld  = 1'b0;
`else
          w_cur_vld  = 1'b0;
`endif
        end else begin
          w_ptr = r_ptr + 2'd1;
        end
      end

      if (w_cap) begin
        if (!w_cur_vld) begin
          w_cur_vld  = 1'b1;
          w_cur_dat  = bus.INSTRUCTION_SET;
          w_cur_line = r_mem_addr[31:4];
        end
`ifdef FETCH_PREFETCH_EN
        else begin
          w_nxt_vld  = 1'b1;
          w_nxt_dat  = bus.INSTRUCTION_SET;
          w_nxt_line = r_mem_addr[31:4];
        end
      end
      w_free = !w_nxt_vld;
`else
      end
      w_free = !w_cur_vld;
`endif

      // MEM_ADDRESS always names the newest line, so the next sequential fetch is simply +16.
      if (w_cap || (r_state == ST_HOLD)) begin
        if (w_free) begin
          w_mem_addr = r_mem_addr + 32'd16;
          w_cnt      = '0;
          w_state    = ST_WAIT;
        end else begin
          w_state = ST_HOLD;
        end
      end else begin
        w_cnt = r_cnt + CW'(1);
      end
    end

    w_instr    = '0;
    w_instr_pc = '0;
    if (w_cur_vld) begin
      w_instr    = f_word(w_cur_dat, w_ptr);
      w_instr_pc = {w_cur_line, w_ptr, 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT;
      r_cnt      <= '0;
      r_mem_addr <= {RESET_PC[31:4], 4'b0000};
      r_ptr      <= RESET_PC[3:2];
      r_cur_vld  <= 1'b0;
      r_cur_dat  <= '0;
      r_cur_line <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
`ifdef FETCH_PREFETCH_EN
      r_nxt_vld  <= 1'b0;
      r_nxt_dat  <= '0;
      r_nxt_line <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_mem_addr <= w_mem_addr;
      r_ptr      <= w_ptr;
      r_cur_vld  <= w_cur_vld;
      r_cur_dat  <= w_cur_dat;
      r_cur_line <= w_cur_line;
      r_instr    <= w_instr;
      r_instr_pc <= w_instr_pc;
`ifdef FETCH_PREFETCH_EN
      r_nxt_vld  <= w_nxt_vld;
      r_nxt_dat  <= w_nxt_dat;
      r_nxt_line <= w_nxt_line;
`endif
    end
  end

  assign bus.MEM_ADDRESS = r_mem_addr;
  assign bus.instr_valid = r_cur_vld;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
endmodule

// File: tb/tb_fetch_line_buffer.sv
// Self-checking bench for fetch_line_buffer: latency-timed memory model plus an in-order PC scoreboard.
module tb_fetch_line_buffer;
  localparam int MEM_LATENCY = 6;
`ifdef FETCH_PREFETCH_EN
  localparam int          BOUNDARY_GAP = MEM_LATENCY + 1 - 4;
  localparam logic [31:0] HOLD_ADDR    = 32'h10;
`else
  localparam int          BOUNDARY_GAP = MEM_LATENCY + 1;
  localparam logic [31:0] HOLD_ADDR    = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_line_buffer_if bus();

  fetch_line_buffer #(.MEM_LATENCY(MEM_LATENCY), .RESET_PC(32'h0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] addr_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory only returns the real line once the address has been stable long enough.
  logic [31:0] m_last = 32'hFFFF_FFFF;
  int          m_age  = 0;
  always @(posedge clk) begin
    if (bus.MEM_ADDRESS !== m_last) begin
      m_last <= bus.MEM_ADDRESS;
      m_age  <= 0;
    end else if (m_age < 1000) begin
      m_age <= m_age + 1;
    end
  end
  always_comb begin
    if ((m_last === bus.MEM_ADDRESS) && (m_age >= MEM_LATENCY - 1))
      bus.INSTRUCTION_SET = {mem_word(m_last), mem_word(m_last + 32'd4),
                             mem_word(m_last + 32'd8), mem_word(m_last + 32'd12)};
    else
      bus.INSTRUCTION_SET = {4{32'hDEAD_BEEF}};
  end

  always @(negedge clk) begin
    if (addr_log.size() == 0 || addr_log[$] !== bus.MEM_ADDRESS)
      addr_log.push_back(bus.MEM_ADDRESS);
  end

  always @(negedge clk) begin : mon
    logic [31:0] exp_pc;
    if (rst_n === 1'b1 && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1 && bus.redirect_valid !== 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: issued pc %h instr %h, expected nothing", bus.instr_pc, bus.instr);
      end else begin
        exp_pc = sb_q.pop_front();
        if (bus.instr_pc !== exp_pc) begin
          n_fail++;
          $display("FAIL sb_pc: got %h, expected %h", bus.instr_pc, exp_pc);
        end
        n_checks++;
        if (bus.instr !== mem_word(exp_pc)) begin
          n_fail++;
          $display("FAIL sb_instr @%h: got %h, expected %h", exp_pc, bus.instr, mem_word(exp_pc));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at 300000 ns");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (bus.instr_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    sb_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    sb_q.delete();
    #1;
    n_checks++; if (bus.MEM_ADDRESS !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h, expected 0", bus.MEM_ADDRESS); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", bus.instr_valid); end
    n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h, expected 0", bus.instr); end
    n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_instr_pc: got %h, expected 0", bus.instr_pc); end
    repeat (2) tick();
    addr_log.delete();
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    push_words(32'h0, 4);
    wait_valid(30, cyc);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL rst_first_latency: got %0d edges, expected 7", cyc); end
  endtask

  task automatic test_stream();
    int words, low_run, n_gap;
    int gaps[2];
    logic [31:0] a0, a1, a2;
    gaps[0] = -1;
    gaps[1] = -1;
    words = 0; low_run = 0; n_gap = 0;
    push_words(32'h10, 8);
    for (int i = 0; i < 200 && words < 12; i++) begin
      if (bus.instr_valid === 1'b1) begin
        if (low_run > 0 && n_gap < 2) begin
          gaps[n_gap] = low_run;
          n_gap++;
        end
        low_run = 0;
        words++;
      end else begin
        low_run++;
      end
      if (words < 12) tick();
    end
    tick();
    bus.instr_ready = 1'b0;
    n_checks++; if (words !== 12) begin n_fail++; $display("FAIL stream_words: got %0d, expected 12", words); end
    n_checks++; if (gaps[0] !== BOUNDARY_GAP) begin n_fail++; $display("FAIL stream_gap0: got %0d, expected %0d", gaps[0], BOUNDARY_GAP); end
    n_checks++; if (gaps[1] !== BOUNDARY_GAP) begin n_fail++; $display("FAIL stream_gap1: got %0d, expected %0d", gaps[1], BOUNDARY_GAP); end
    a0 = (addr_log.size() > 0) ? addr_log[0] : 32'hX;
    a1 = (addr_log.size() > 1) ? addr_log[1] : 32'hX;
    a2 = (addr_log.size() > 2) ? addr_log[2] : 32'hX;
    n_checks++; if (a0 !== 32'h00) begin n_fail++; $display("FAIL stream_addr0: got %h, expected 00000000", a0); end
    n_checks++; if (a1 !== 32'h10) begin n_fail++; $display("FAIL stream_addr1: got %h, expected 00000010", a1); end
    n_checks++; if (a2 !== 32'h20) begin n_fail++; $display("FAIL stream_addr2: got %h, expected 00000020", a2); end
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL stream_pending: %0d words left, expected 0", sb_q.size()); end
  endtask

  task automatic test_stall();
    int cyc;
    do_reset();
    wait_valid(30, cyc);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL stall_latency: got %0d, expected 7", cyc); end
    push_words(32'h0, 1);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4 || bus.instr !== mem_word(32'h4)) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got v=%b pc=%h instr=%h, expected v=1 pc=00000004 instr=%h",
                 i, bus.instr_valid, bus.instr_pc, bus.instr, mem_word(32'h4));
      end
      tick();
    end
    n_checks++; if (bus.MEM_ADDRESS !== HOLD_ADDR) begin n_fail++; $display("FAIL stall_mem_addr: got %h, expected %h", bus.MEM_ADDRESS, HOLD_ADDR); end
    push_words(32'h4, 3);
    bus.instr_ready = 1'b1;
    repeat (3) tick();
    bus.instr_ready = 1'b0;
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL stall_pending: %0d words left, expected 0", sb_q.size()); end
  endtask

  task automatic test_redirect();
    int cyc;
    do_reset();
    bus.instr_ready = 1'b1;
    push_words(32'h0, 4);
    wait_valid(30, cyc);
    repeat (4) tick();
    n_checks++; if (bus.MEM_ADDRESS !== 32'h10 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_pre: got addr %h v=%b, expected 00000010 v=0", bus.MEM_ADDRESS, bus.instr_valid); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0128;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.MEM_ADDRESS !== 32'h120) begin n_fail++; $display("FAIL redir_mem_addr: got %h, expected 00000120", bus.MEM_ADDRESS); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b, expected 0", bus.instr_valid); end
    push_words(32'h128, 3);
    wait_valid(30, cyc);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL redir_latency: got %0d, expected 7", cyc); end
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) tick();
    bus.instr_ready = 1'b0;
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL redir_pending: %0d words left, expected 0", sb_q.size()); end
  endtask

  task automatic test_redirect_collision();
    int cyc;
    do_reset();
    wait_valid(30, cyc);
    push_words(32'h0, 3);
    bus.instr_ready = 1'b1;
    repeat (3) tick();
    bus.instr_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hC) begin n_fail++; $display("FAIL coll_pre: got v=%b pc=%h, expected v=1 pc=0000000c", bus.instr_valid, bus.instr_pc); end
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0240;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL coll_valid: got %b, expected 0", bus.instr_valid); end
    n_checks++; if (bus.MEM_ADDRESS !== 32'h240) begin n_fail++; $display("FAIL coll_mem_addr: got %h, expected 00000240", bus.MEM_ADDRESS); end
    push_words(32'h240, 2);
    wait_valid(30, cyc);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL coll_latency: got %0d, expected 7", cyc); end
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) tick();
    bus.instr_ready = 1'b0;
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL coll_pending: %0d words left, expected 0", sb_q.size()); end
  endtask

  task automatic test_async_reset();
    int cyc;
    do_reset();
    wait_valid(30, cyc);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL arst_drain_valid: got %b, expected 0", bus.instr_valid); end
    n_checks++; if (bus.MEM_ADDRESS !== 32'h0 || bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL arst_drain_state: got addr %h pc %h, expected 0 0", bus.MEM_ADDRESS, bus.instr_pc); end
    tick();
    rst_n = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.MEM_ADDRESS !== 32'h0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL arst_wait: got addr %h v=%b, expected 0 v=0", bus.MEM_ADDRESS, bus.instr_valid); end
    tick();
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    push_words(32'h0, 2);
    wait_valid(30, cyc);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL arst_resume_latency: got %0d, expected 7", cyc); end
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick();
    bus.instr_ready = 1'b0;
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL arst_pending: %0d words left, expected 0", sb_q.size()); end
  endtask

`ifdef FETCH_PREFETCH_EN
  task automatic test_prefetch_no_bubble();
    int cyc, low;
    do_reset();
    wait_valid(30, cyc);
    push_words(32'h0, 12);
    low = 0;
    for (int i = 0; i < 200 && sb_q.size() > 0; i++) begin
      bus.instr_ready = (i % 2 == 0);
      if (bus.instr_valid !== 1'b1) low++;
      tick();
    end
    bus.instr_ready = 1'b0;
    n_checks++; if (low !== 0) begin n_fail++; $display("FAIL pf_bubbles: got %0d idle cycles, expected 0", low); end
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL pf_pending: %0d words left, expected 0", sb_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_collision();
    test_async_reset();
`ifdef FETCH_PREFETCH_EN
    test_prefetch_no_bubble();
`endif
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
